debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Parametrised N-channel push-button conditioner; successor to the single-channel level debouncer.
Each channel is synchronised, then debounced symmetrically, so both press and release must be stable before they are accepted.
Each channel gives a clean level plus one-cycle press/release event pulses.
Sits between board button/switch pins and the LED/FSM control logic; one instance serves all buttons.

Parameters:
N_CH, 4, number of independent button channels (1..32)
STABLE_CYCLES, 25000000, consecutive cycles a new level must persist before acceptance (>=2)
ACTIVE_LOW, 0, 1 = raw pins are active-low; inverted before synchronisation
CNT_W, $clog2(STABLE_CYCLES), debounce counter width; derived, do not override

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_in  input  N_CH  raw asynchronous button pins
btn_state  output  N_CH  debounced level per channel; 1 = pressed
btn_press  output  N_CH  one-cycle pulse on accepted 0->1
btn_release  output  N_CH  one-cycle pulse on accepted 1->0
any_press  output  1  OR of btn_press, registered in the same cycle as btn_press
btn_repeat  output  N_CH  auto-repeat pulses; tied 0 unless the optional feature is enabled

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0, all synchroniser flops, counters, btn_state, btn_press, btn_release, any_press and btn_repeat are 0.
  - Deassertion of rst_n is synchronised externally.
- Input conditioning: the level after optional inversion passes through a 2-flop synchroniser per channel (s0 -> s1).
  - Only s1 is used downstream.
- Per-channel debounce, evaluated every edge:
  - If s1 == btn_state: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: btn_state <= s1, cnt <= 0, and btn_press or btn_release is set for that cycle.
  - Else: cnt <= cnt+1.
- Latency: a new level first captured by s0 at edge k flips btn_state at edge k+1+STABLE_CYCLES, provided the input holds.
- Glitches:
  - Any return of s1 to btn_state before acceptance clears cnt.
  - The full STABLE_CYCLES count restarts on the next mismatch.
- Counter saturation is impossible: cnt never exceeds STABLE_CYCLES-1.
- Pulses:
  - btn_press and btn_release are registered and high for exactly one cycle, coincident with the btn_state update.
  - They are never both high on the same channel.
- Channels are fully independent. Simultaneous acceptances on several channels produce simultaneous pulses, and any_press is high for that one cycle.
- Reset mid-count: the count is discarded. After release, a button held down is accepted as a press STABLE_CYCLES+1 edges after the first post-reset sampling edge.
- No combinational path from btn_in to any output.

Optional Feature:
Macro DEBOUNCE_REPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 50000000) and REPEAT_PERIOD (default 10000000), plus a per-channel repeat counter.
  - While btn_state=1, the first btn_repeat pulse occurs REPEAT_DELAY cycles after the btn_press cycle.
  - Further pulses follow every REPEAT_PERIOD cycles.
  - A release clears the repeat counter immediately; no pulse occurs in the release cycle.
  - btn_repeat is one cycle wide and is not ORed into any_press.
- Undefined: no repeat counters are synthesised, and btn_repeat is driven constant 0.

Decomposition:
- Package debounce_pkg:
  - CNT_W derivation function (clog2).
  - Default STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
  - Channel event typedef {state, press, release, repeat}.
- Sub-module debounce_channel (single channel: synchroniser, counter, edge pulses, optional repeat), instantiated N_CH times in a generate loop.
- Top level holds only the ACTIVE_LOW inversion, the generate loop and the any_press OR register.

Test Plan:
1. Reset: rst_n=0 with btn_in=4'hF asserted mid-run -> all outputs 0 asynchronously. After release, with STABLE_CYCLES=4 and btn_in held, btn_state=4'hF and btn_press=4'hF exactly 5 edges after the first sampling edge.
2. Clean press, STABLE_CYCLES=4: btn_in[0] 0->1 sampled at edge 0 -> btn_state[0] and btn_press[0] rise at edge 5. btn_press[0] is low at edge 6, and any_press pulses at edge 5.
3. Bounce: btn_in[1] high 3 cycles, low 1 cycle, then high steady -> no pulse during the bounce. The press is accepted 5 edges after the final rising sample.
4. Release symmetry: hold ch2 pressed, drop btn_in[2] -> btn_release[2] is a single cycle 5 edges after sampling. A 2-cycle low glitch produces no release.
5. Simultaneous and polarity: ACTIVE_LOW=1, btn_in 4'hF->4'h5 -> btn_state=4'hA and btn_press=4'hA in the same cycle, with one any_press pulse.
6. DEBOUNCE_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, ch0 held:
   - btn_repeat[0] pulses 8 cycles after btn_press[0], then every 3 cycles.
   - Release stops the pulses.
   - Undefined build: btn_repeat is always 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, counter-width helper and per-channel event record for the
// multi-channel button debouncer.
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 25000000;
    localparam int DEF_REPEAT_DELAY  = 50000000;
    localparam int DEF_REPEAT_PERIOD = 10000000;

    // A counter that must reach n-1 needs $clog2(n) bits; keep at least one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic state;
        logic press;
        logic rel;
        logic rpt;
    } ch_event_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, symmetric stability counter and
// registered edge pulses. Auto-repeat is built only with DEBOUNCE_REPEAT_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = cnt_width(STABLE_CYCLES)
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      din,
    output ch_event_t ev,
    output logic      press_next
);

    logic             s0_q, s0_d, s1_q, s1_d;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             rpt_bit;

    always_comb begin
        s0_d    = din;
        s1_d    = s0_q;
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        accept  = 1'b0;
        // The count only runs while the synchronised level disagrees with the
        // accepted one, so any bounce back to the old level restarts it.
        if (s1_q != state_q) begin
            if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                accept  = 1'b1;
                state_d = s1_q;
                press_d = s1_q;
                rel_d   = ~s1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_done_q, rpt_done_d;
    logic             rpt_q, rpt_d;

    // rpt_done_q switches the reload target from the initial delay to the period.
    always_comb begin
        rpt_cnt_d  = '0;
        rpt_done_d = 1'b0;
        rpt_d      = 1'b0;
        if (state_q && !accept) begin
            rpt_done_d = rpt_done_q;
            if (rpt_cnt_q == (rpt_done_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1))) begin
                rpt_d      = 1'b1;
                rpt_done_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q  <= '0;
            rpt_done_q <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_done_q <= rpt_done_d;
            rpt_q      <= rpt_d;
        end
    end

    assign rpt_bit = rpt_q;
`else
    assign rpt_bit = 1'b0;
`endif

    assign ev         = '{state: state_q, press: press_q, rel: rel_q, rpt: rpt_bit};
    assign press_next = press_d;

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: optional pin inversion, one debounce
// channel per button and a registered any_press. Optional DEBOUNCE_REPEAT_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 0,
    parameter int CNT_W         = cnt_width(STABLE_CYCLES)
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            any_press,
    output logic [N_CH-1:0] btn_repeat
);

    logic [N_CH-1:0] din;
    logic [N_CH-1:0] press_next;
    logic            any_press_q, any_press_d;

    assign din = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        ch_event_t ev;

        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
`ifdef DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (din[gi]),
            .ev         (ev),
            .press_next (press_next[gi])
        );

        assign btn_state[gi]   = ev.state;
        assign btn_press[gi]   = ev.press;
        assign btn_release[gi] = ev.rel;
        assign btn_repeat[gi]  = ev.rpt;
    end

    // Built from the channels' next-press terms so it lands with btn_press.
    always_comb begin
        any_press_d = |press_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi with STABLE_CYCLES=4: vector table plus hand
// sequences for reset, polarity and (with DEBOUNCE_REPEAT_EN) auto-repeat.
module tb_debounce_multi;

    localparam int NONE = 99;
`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [16:0] TBL_MASK = 17'h1FFF0;
`else
    localparam logic [16:0] TBL_MASK = 17'h1FFFF;
`endif
    localparam logic [16:0] FULL_MASK = 17'h1FFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = 4'h0;
    logic [3:0] btn_in_n = 4'hF;
    logic [3:0] st, pr, rl, rp;
    logic       ap;
    logic [3:0] st_n, pr_n, rl_n, rp_n;
    logic       ap_n;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(0)
`ifdef DEBOUNCE_REPEAT_EN
        , .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(st), .btn_press(pr),
        .btn_release(rl), .any_press(ap), .btn_repeat(rp)
    );

    debounce_multi #(
        .N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1)
`ifdef DEBOUNCE_REPEAT_EN
        , .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
`endif
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in_n), .btn_state(st_n), .btn_press(pr_n),
        .btn_release(rl_n), .any_press(ap_n), .btn_repeat(rp_n)
    );

    typedef struct {
        string      name;
        logic [3:0] btn;
        int         hold;
        int         chk;
        logic [3:0] new_state;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

    vec_t        tbl[12];
    logic [16:0] exp_q[$];
    logic [3:0]  cur_state = 4'h0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [16:0] pack(input logic [3:0] s, input logic [3:0] p,
                                         input logic [3:0] r, input logic a, input logic [3:0] t);
        return {s, p, r, a, t};
    endfunction

    function automatic logic [16:0] obs();
        return pack(st, pr, rl, ap, rp);
    endfunction

    function automatic logic [16:0] obs_n();
        return pack(st_n, pr_n, rl_n, ap_n, rp_n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] mask);
        logic [16:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
            return;
        end
        exp = exp_q.pop_front();
        if ((got & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got {st,pr,rl,any,rpt}=%h required %h (mask %h)", name, got, exp, mask);
        end
    endtask

    // Edge 0 is the first edge after btn changes; acceptance lands on edge chk.
    task automatic run_edges(input string name, input logic [3:0] btn, input int hold, input int chk,
                             input logic [3:0] new_state, input logic [3:0] press, input logic [3:0] rel);
        btn_in = btn;
        for (int j = 0; j < hold; j++) begin
            exp_q.push_back(pack((j >= chk) ? new_state : cur_state,
                                 (j == chk) ? press : 4'h0,
                                 (j == chk) ? rel : 4'h0,
                                 (j == chk) && (press != 4'h0), 4'h0));
        end
        for (int j = 0; j < hold; j++) begin
            step();
            check(name, obs(), TBL_MASK);
        end
        if (chk < hold) cur_state = new_state;
    endtask

    initial begin
        tbl[0]  = '{"clean_press",    4'h1, 8, 5,    4'h1, 4'h1, 4'h0};
        tbl[1]  = '{"bounce_high",    4'h3, 3, NONE, 4'h1, 4'h0, 4'h0};
        tbl[2]  = '{"bounce_low",     4'h1, 1, NONE, 4'h1, 4'h0, 4'h0};
        tbl[3]  = '{"bounce_settle",  4'h3, 8, 5,    4'h3, 4'h2, 4'h0};
        tbl[4]  = '{"ch2_press",      4'h7, 8, 5,    4'h7, 4'h4, 4'h0};
        tbl[5]  = '{"ch2_release",    4'h3, 8, 5,    4'h3, 4'h0, 4'h4};
        tbl[6]  = '{"ch2_repress",    4'h7, 8, 5,    4'h7, 4'h4, 4'h0};
        tbl[7]  = '{"glitch_low",     4'h3, 2, NONE, 4'h7, 4'h0, 4'h0};
        tbl[8]  = '{"glitch_recover", 4'h7, 8, NONE, 4'h7, 4'h0, 4'h0};
        tbl[9]  = '{"multi_release",  4'h0, 8, 5,    4'h0, 4'h0, 4'h7};
        tbl[10] = '{"multi_press",    4'hC, 8, 5,    4'hC, 4'hC, 4'h0};
        tbl[11] = '{"multi_release2", 4'h0, 8, 5,    4'h0, 4'h0, 4'hC};

        // Power-on reset
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back('0);
            step();
            check("reset_state", obs(), FULL_MASK);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_edges(tbl[i].name, tbl[i].btn, tbl[i].hold, tbl[i].chk,
                      tbl[i].new_state, tbl[i].press, tbl[i].rel);
        end

        // Active-low instance: pins F->5 means channels 1 and 3 pressed
        btn_in_n = 4'h5;
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back(pack((j >= 5) ? 4'hA : 4'h0, (j == 5) ? 4'hA : 4'h0, 4'h0, j == 5, 4'h0));
            step();
            check("active_low_press", obs_n(), FULL_MASK);
        end

        // Reset in the middle of a run drops everything asynchronously
        run_edges("pre_reset_press", 4'hF, 8, 5, 4'hF, 4'hF, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        check("async_reset", obs(), FULL_MASK);
        for (int j = 0; j < 2; j++) begin
            exp_q.push_back('0);
            step();
            check("reset_held", obs(), FULL_MASK);
        end
        rst_n = 1'b1;
        cur_state = 4'h0;
        run_edges("post_reset_press", 4'hF, 8, 5, 4'hF, 4'hF, 4'h0);

`ifdef DEBOUNCE_REPEAT_EN
        run_edges("release_all", 4'h0, 8, 5, 4'h0, 4'h0, 4'hF);
        // ch0 pressed at edge 5 (r=0); released so that release lands on r=23,
        // which is also where the next repeat would otherwise fall.
        btn_in = 4'h1;
        for (int j = 0; j < 36; j++) begin
            int r;
            r = j - 5;
            exp_q.push_back(pack({3'b0, (r >= 0) && (r < 23)},
                                 {3'b0, r == 0},
                                 {3'b0, r == 23},
                                 r == 0,
                                 {3'b0, (r >= 8) && (r < 23) && ((r - 8) % 3 == 0)}));
            step();
            check("repeat_seq", obs(), FULL_MASK);
            if (j == 22) btn_in = 4'h0;
        end
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
